// File: rtl/score_game_ctrl_if.sv
// Bus between the game controller and its surroundings: tick/collision/start
// inputs towards the controller, score and HUD status back out.
interface score_game_ctrl_if #(
  parameter int SCORE_W = 12
);
  logic               start;
  logic               frame;
  logic               collision;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               playing;
  logic               game_over;
  logic               new_high;
  logic               clear_score;
  logic               blink;

  modport slave (
    input  start,
    input  frame,
    input  collision,
    output score,
    output high_score,
    output playing,
    output game_over,
    output new_high,
    output clear_score,
    output blink
  );

  modport master (
    output start,
    output frame,
    output collision,
    input  score,
    input  high_score,
    input  playing,
    input  game_over,
    input  new_high,
    input  clear_score,
    input  blink
  );
endinterface

// File: rtl/score_game_ctrl.sv
// Meteor-game controller: IDLE/PLAY/LATCH/OVER sequencing, prescaled scoring,
// high-score retention and new-record blink. Every output comes from a flop.
module score_game_ctrl #(
  parameter int SCORE_W          = 12,
  parameter int FRAMES_PER_POINT = 4,
  parameter int BLINK_FRAMES     = 8
) (
  input  logic                clk,
  input  logic                reset,
  score_game_ctrl_if.slave    bus
);

  localparam int PRESC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(FRAMES_PER_POINT - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_LATCH = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic [SCORE_W-1:0]   score_q,     score_d;
  logic [SCORE_W-1:0]   high_q,      high_d;
  logic [PRESC_W-1:0]   presc_q,     presc_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_q,     blink_d;
  logic                 new_high_q,  new_high_d;
  logic                 clear_q,     clear_d;
  logic                 playing_q,   playing_d;
  logic                 over_q,      over_d;

  // State and datapath registers; reset clears everything, high score included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      high_q      <= '0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      new_high_q  <= 1'b0;
      clear_q     <= 1'b0;
      playing_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      new_high_q  <= new_high_d;
      clear_q     <= clear_d;
      playing_q   <= playing_d;
      over_q      <= over_d;
    end
  end

  // Next-state and datapath update for the game sequence.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    high_d      = high_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    new_high_d  = new_high_q;
    clear_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_PLAY;
          score_d     = '0;
          presc_d     = '0;
          new_high_d  = 1'b0;
          blink_d     = 1'b0;
          blink_cnt_d = '0;
          clear_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PLAY: begin
        // Collision outranks a coincident frame: no increment, no prescaler step.
        if (bus.collision) begin
          state_d = S_LATCH;
        end else if (bus.frame) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
            end else begin
              score_d = score_q;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end else begin
          state_d = S_PLAY;
        end
      end

      S_LATCH: begin
        state_d = S_OVER;
        if (score_q > high_q) begin
          high_d     = score_q;
          new_high_d = 1'b1;
        end else begin
          new_high_d = 1'b0;
        end
      end

      S_OVER: begin
        if (bus.start) begin
          state_d     = S_PLAY;
          score_d     = '0;
          presc_d     = '0;
          new_high_d  = 1'b0;
          blink_d     = 1'b0;
          blink_cnt_d = '0;
          clear_d     = 1'b1;
        end else if (new_high_q && bus.frame) begin
          if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
        end else begin
          state_d = S_OVER;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags follow the next state so they line up with state_q after the edge.
  always_comb begin
    playing_d = (state_d == S_PLAY);
    over_d    = (state_d == S_OVER);
  end

  assign bus.score       = score_q;
  assign bus.high_score  = high_q;
  assign bus.playing     = playing_q;
  assign bus.game_over   = over_q;
  assign bus.new_high    = new_high_q;
  assign bus.clear_score = clear_q;
  assign bus.blink       = blink_q;

endmodule

// File: tb/tb_score_game_ctrl.sv
// Bench for score_game_ctrl: directed scenarios plus random play, all checked
// against a counting model of the game rules.
module tb_score_game_ctrl;

  localparam int SCORE_W = 12;
  localparam int FPP     = 4;
  localparam int BLINKF  = 8;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_LATCH = 2, PH_OVER = 3;

  logic clk;
  logic reset;

  score_game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  score_game_ctrl #(
    .SCORE_W(SCORE_W), .FRAMES_PER_POINT(FPP), .BLINK_FRAMES(BLINKF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Model: game phase plus plain counts of qualifying frames.
  int m_phase;
  int m_frames;
  int m_over_frames;
  int m_high;
  bit m_new;
  bit m_clear;
  int clear_cnt;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_score();
    int s;
    s = m_frames / FPP;
    return (s > SMAX) ? SMAX : s;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_frames = 0; m_over_frames = 0;
    m_high = 0; m_new = 1'b0; m_clear = 1'b0;
  endtask

  task automatic model_begin_game();
    m_phase = PH_PLAY; m_frames = 0; m_over_frames = 0;
    m_new = 1'b0; m_clear = 1'b1;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit c);
    m_clear = 1'b0;
    case (m_phase)
      PH_IDLE:  if (s) model_begin_game();
      PH_PLAY: begin
        if (c)      m_phase = PH_LATCH;
        else if (f) m_frames++;
      end
      PH_LATCH: begin
        if (m_score() > m_high) begin
          m_high = m_score();
          m_new  = 1'b1;
        end
        m_phase = PH_OVER;
      end
      default: begin
        if (s)                model_begin_game();
        else if (m_new && f)  m_over_frames++;
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("score",       int'(bus.score),      m_score());
    check_val("high_score",  int'(bus.high_score), m_high);
    check_val("playing",     int'(bus.playing),    (m_phase == PH_PLAY) ? 1 : 0);
    check_val("game_over",   int'(bus.game_over),  (m_phase == PH_OVER) ? 1 : 0);
    check_val("new_high",    int'(bus.new_high),   int'(m_new));
    check_val("clear_score", int'(bus.clear_score), int'(m_clear));
    check_val("blink",       int'(bus.blink),
              m_new ? ((m_over_frames / BLINKF) % 2) : 0);
  endtask

  // Drive at the falling edge, clock, sample 1 time unit after the rising edge.
  task automatic step(input bit s, input bit f, input bit c);
    bus.start = s; bus.frame = f; bus.collision = c;
    @(posedge clk);
    model_edge(s, f, c);
    #1;
    compare_all();
    if (bus.clear_score === 1'b1) clear_cnt++;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; clear_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.frame = 1'b0; bus.collision = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Game 1: start, scoring cadence, record 5 and blink
    step(1'b1, 1'b0, 1'b0);
    check_val("t1_clear", int'(bus.clear_score), 1);
    frames(4);
    check_val("t1_score4", int'(bus.score), 1);
    frames(4);
    check_val("t1_score8", int'(bus.score), 2);
    check_val("t1_playing", int'(bus.playing), 1);
    check_val("t1_clear_once", int'(bus.clear_score), 0);
    frames(12);
    step(1'b0, 1'b0, 1'b1);
    check_val("t2_latch_over", int'(bus.game_over), 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("t2_over", int'(bus.game_over), 1);
    check_val("t2_high", int'(bus.high_score), 5);
    check_val("t2_new", int'(bus.new_high), 1);
    frames(7);
    check_val("t2_blink7", int'(bus.blink), 0);
    frames(1);
    check_val("t2_blink8", int'(bus.blink), 1);
    frames(8);
    check_val("t2_blink16", int'(bus.blink), 0);

    // Game 2: lower score; game 3: equal score
    step(1'b1, 1'b0, 1'b0);
    frames(12);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("t3_high", int'(bus.high_score), 5);
    check_val("t3_new", int'(bus.new_high), 0);
    frames(8);
    check_val("t3_blink", int'(bus.blink), 0);
    step(1'b1, 1'b0, 1'b0);
    frames(20);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("t3_eq_new", int'(bus.new_high), 0);

    // Coincident frame and collision with prescaler at 3
    step(1'b1, 1'b0, 1'b0);
    frames(7);
    step(1'b0, 1'b1, 1'b1);
    check_val("t4_score", int'(bus.score), 1);
    check_val("t4_latch", int'(bus.playing), 0);
    step(1'b0, 1'b0, 1'b0);

    // Saturation
    step(1'b1, 1'b0, 1'b0);
    frames(SMAX * FPP + 8 * FPP);
    check_val("t4_sat", int'(bus.score), SMAX);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("t4_sat_high", int'(bus.high_score), SMAX);

    // Async reset mid-play, then frames in IDLE
    step(1'b1, 1'b0, 1'b0);
    frames(9);
    async_reset();
    check_val("t5_high_lost", int'(bus.high_score), 0);
    frames(5);
    check_val("t5_idle_score", int'(bus.score), 0);

    // start held high throughout
    clear_cnt = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_val("t6_over", int'(bus.game_over), 1);
    check_val("t6_one_clear", clear_cnt, 1);
    step(1'b1, 1'b0, 1'b0);
    check_val("t6_restart_clear", int'(bus.clear_score), 1);
    check_val("t6_restart_score", int'(bus.score), 0);

    // Random play with occasional asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 39) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_game_ctrl.md
Name: score_game_ctrl

Overview:
Game-level controller that sequences the score datapath for the meteor-dodging game. A state machine (IDLE, PLAY, LATCH, OVER) gates frame ticks into score increments through a prescaler. On collision it freezes the score, compares it against a retained high score, and drives status and blink outputs for the HUD and hex display logic. It sits between the frame-tick generator / collision detector and the score display path.

Parameters:
SCORE_W, 12, width of score and high_score
FRAMES_PER_POINT, 4, frame pulses per score increment (>=1)
BLINK_FRAMES, 8, frame pulses per blink toggle in OVER (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  level/pulse; sampled each cycle, begins a game
frame  input  1  one-cycle pulse per video frame
collision  input  1  one-cycle pulse, player hit a meteor
score  output  SCORE_W  current game score
high_score  output  SCORE_W  best score since reset
playing  output  1  high in PLAY
game_over  output  1  high in OVER
new_high  output  1  last finished game set a new high score
clear_score  output  1  one-cycle pulse when a game starts
blink  output  1  display blink enable

Behaviour:
- Reset (async, active-high), all outputs and state forced immediately: state=IDLE, score=0, high_score=0, prescaler=0, blink counter=0, playing=0, game_over=0, new_high=0, clear_score=0, blink=0.
- States:
  - IDLE: start=1 -> PLAY. frame and collision ignored.
  - PLAY: counts frames; collision=1 -> LATCH; start ignored.
  - LATCH: exactly one cycle; compare, then -> OVER unconditionally.
  - OVER: start=1 -> PLAY; otherwise stay.
- Game start (IDLE->PLAY or OVER->PLAY), on the transition edge: score<=0, prescaler<=0, new_high<=0, blink<=0, blink counter<=0, clear_score<=1 for exactly one cycle (registered; asserted in the first PLAY cycle).
- Scoring in PLAY: on each frame=1 with collision=0:
  - if prescaler==FRAMES_PER_POINT-1: prescaler<=0 and score<=score+1;
  - else prescaler<=prescaler+1.
  - Score is visible one cycle after the qualifying frame pulse.
  - Score saturates at 2^SCORE_W-1 (4095 default): no wrap, while the prescaler keeps cycling.
- Simultaneous frame and collision in PLAY: collision wins; no increment, no prescaler advance; -> LATCH.
- LATCH: if score > high_score (strict), high_score<=score and new_high<=1; equal score leaves new_high=0. score holds.
- OVER: score and high_score hold; game_over=1.
  - If new_high=1, each frame pulse advances the blink counter; at BLINK_FRAMES-1 it wraps to 0 and blink toggles.
  - If new_high=0, blink stays 0.
- playing = (state==PLAY); game_over = (state==OVER). Both are registered/decoded from state and are never high together.
- start held high continuously: starts exactly one game; it is not re-evaluated in PLAY, so it has no effect until OVER.
- Reset mid-game: immediate return to IDLE; high_score is lost (cleared).
- No combinational path from any input to any output.

Test Plan:
- Reset, start pulse, 8 frame pulses, no collision -> clear_score high for 1 cycle after start; score=1 after the 4th frame, 2 after the 8th; playing=1.
- Play to score=5, collision -> LATCH 1 cycle, then game_over=1, high_score=5, new_high=1. Apply 16 frames -> blink toggles after frames 8 and 16 (1 then 0).
- Second game: start, reach score=3, collision -> high_score stays 5, new_high=0, blink=0. Third game reaching exactly 5 -> new_high=0.
- Frame and collision in the same cycle with prescaler=3 -> score unchanged, state goes to LATCH. Also force score to 4095 and apply 8 more frames -> score stays 4095.
- Assert reset asynchronously mid-PLAY, between clock edges -> all outputs 0 immediately, state IDLE. Frame pulses in IDLE -> score stays 0.
- Hold start=1 from IDLE through a collision -> exactly one clear_score pulse at entry. After collision: LATCH, then OVER for one cycle, then an immediate restart with a new clear_score pulse and score=0.
